// File: rtl/bus_source_arbiter.sv
// Round-robin owner arbiter that produces the registered 24-source bus select code and one-hot grant.
// Optional sticky multi-request flag is built only when BUS_CONFLICT_DETECT_EN is defined.
module bus_source_arbiter #(
  parameter int             NUM_SRC   = 24,
  parameter int             SEL_W     = 5,
  parameter logic [SEL_W-1:0] IDLE_CODE = 5'd31
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] out_req,
  input  logic               conflict_clr,
  output logic [SEL_W-1:0]   Sout,
  output logic [NUM_SRC-1:0] grant,
  output logic               bus_busy,
  output logic               conflict
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } st_t;

  localparam logic [SEL_W-1:0]   LAST_RST = SEL_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

  st_t                st_q, st_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   sout_q, sout_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [SEL_W:0]     pick_s;
  logic               need_arb_s;

  // Returns {found, index} of the first request after 'last', wrapping modulo NUM_SRC.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                             input logic [SEL_W-1:0]   last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] sel;
    int               idx;
    res = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_SRC;
      sel = SEL_W'(idx);
      if (req[sel]) begin
        res = {1'b1, sel};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Ownership and round-robin next state; outputs precomputed so they leave a register.
  always_comb begin
    st_d       = st_q;
    owner_d    = owner_q;
    last_d     = last_q;
    need_arb_s = 1'b0;
    pick_s     = rr_pick(out_req, last_q);

    case (st_q)
      ST_IDLE:  need_arb_s = 1'b1;
      ST_OWNED: begin
        if (out_req[owner_q]) begin
          need_arb_s = 1'b0;
        end else begin
          need_arb_s = 1'b1;
        end
      end
      default:  need_arb_s = 1'b1;
    endcase

    // Release re-arbitrates on the same edge, so a waiting source sees no idle bubble.
    if (need_arb_s) begin
      if (pick_s[SEL_W]) begin
        st_d    = ST_OWNED;
        owner_d = pick_s[SEL_W-1:0];
        last_d  = pick_s[SEL_W-1:0];
      end else begin
        st_d    = ST_IDLE;
      end
    end else begin
      st_d = st_q;
    end

    if (st_d == ST_OWNED) begin
      sout_d  = owner_d;
      grant_d = ONE_HOT0 << owner_d;
      busy_d  = 1'b1;
    end else begin
      sout_d  = IDLE_CODE;
      grant_d = '0;
      busy_d  = 1'b0;
    end
  end

  // State and output registers; clear drops ownership regardless of requests.
  always_ff @(posedge clock) begin
    if (clear) begin
      st_q    <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      sout_q  <= IDLE_CODE;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sout_q  <= sout_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_CONFLICT_DETECT_EN
  logic conflict_q, conflict_d;

  // popcount >= 2 is equivalent to clearing the lowest set bit leaving something behind.
  function automatic logic multi_req(input logic [NUM_SRC-1:0] req);
    return |(req & (req - ONE_HOT0));
  endfunction

  // Sticky flag: a new multi-request beats a simultaneous clear.
  always_comb begin
    if (multi_req(out_req)) begin
      conflict_d = 1'b1;
    end else if (conflict_clr) begin
      conflict_d = 1'b0;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict flag register.
  always_ff @(posedge clock) begin
    if (clear) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;
`else
  logic unused_conflict_clr;
  assign unused_conflict_clr = conflict_clr;
  assign conflict            = 1'b0;
`endif

  assign Sout     = sout_q;
  assign grant    = grant_q;
  assign bus_busy = busy_q;

endmodule
